// File: rtl/ctrl_resolve_redirect.sv
// ctrl_resolve_redirect
// Branch-resolution stage behind the control-ALU. It does two things:
//   - Holds the oldest pending misprediction as a redirect request to fetch.
//     Age is measured relative to the ROB head. The request is held until
//     fetch accepts it, a full flush clears it, or an older misprediction
//     replaces it.
//   - Queues resolved conditional-branch outcomes in a small FIFO that feeds
//     the predictor/BTB update port. Pushes that arrive while the FIFO is
//     full are dropped and counted.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   exe*_i              resolved control instruction from the control-ALU
//   robHead_i           ROB head index, the reference point for age
//   flush_i             full pipeline flush
//   redirect*_o / redirectReady_i   redirect handshake to fetch
//   upd*_o / updReady_i             predictor-update FIFO head handshake
//   updDropCnt_o        saturating count of dropped updates
module ctrl_resolve_redirect #(
  parameter int unsigned SIZE_PC      = 32,
  parameter int unsigned SIZE_ROB_LOG = 7,
  parameter int unsigned UPD_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    exeValid_i,
  input  logic [SIZE_PC-1:0]      exePC_i,
  input  logic [SIZE_PC-1:0]      exeNextPC_i,
  input  logic                    exeDirection_i,
  input  logic [7:0]              exeFlags_i,
  input  logic [SIZE_ROB_LOG-1:0] exeRobId_i,
  input  logic [SIZE_ROB_LOG-1:0] robHead_i,
  input  logic                    flush_i,
  output logic                    redirectValid_o,
  output logic [SIZE_PC-1:0]      redirectPC_o,
  output logic [SIZE_ROB_LOG-1:0] redirectRobId_o,
  input  logic                    redirectReady_i,
  output logic                    updValid_o,
  output logic [SIZE_PC-1:0]      updPC_o,
  output logic [SIZE_PC-1:0]      updTarget_o,
  output logic                    updDir_o,
  input  logic                    updReady_i,
  output logic [7:0]              updDropCnt_o
);

  localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [SIZE_PC-1:0] pc;
    logic [SIZE_PC-1:0] target;
    logic               dir;
  } upd_entry_t;

  // Flag bits this stage does not consume.
  logic unused_flags;
  assign unused_flags = ^{exeFlags_i[7:6], exeFlags_i[4:3], exeFlags_i[1]};

  // ---------------------------------------------------------------------------
  // Redirect register
  // ---------------------------------------------------------------------------
  logic                    redir_valid_q;
  logic [SIZE_PC-1:0]      redir_pc_q;
  logic [SIZE_ROB_LOG-1:0] redir_rob_q;

  logic                    cand_c;
  logic                    accept_c;
  logic                    older_c;
  logic                    load_c;
  logic [SIZE_ROB_LOG-1:0] cand_age_c;
  logic [SIZE_ROB_LOG-1:0] held_age_c;

  // Age is the modular distance from the ROB head; the subtraction wraps at
  // the tag width.
  assign cand_age_c = exeRobId_i - robHead_i;
  assign held_age_c = redir_rob_q - robHead_i;

  assign cand_c   = exeValid_i & exeFlags_i[0] & exeFlags_i[5];
  assign accept_c = redir_valid_q & redirectReady_i;
  assign older_c  = cand_age_c < held_age_c;
  assign load_c   = cand_c & (~redir_valid_q | accept_c | older_c);

  // A flush beats a load and an accept. A load beats an accept, so valid
  // stays set across a same-cycle accept plus a new misprediction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_rob_q   <= '0;
    end else if (flush_i) begin
      redir_valid_q <= 1'b0;
    end else if (load_c) begin
      redir_valid_q <= 1'b1;
      redir_pc_q    <= exeNextPC_i;
      redir_rob_q   <= exeRobId_i;
    end else if (accept_c) begin
      redir_valid_q <= 1'b0;
    end
  end

  assign redirectValid_o = redir_valid_q;
  assign redirectPC_o    = redir_pc_q;
  assign redirectRobId_o = redir_rob_q;

  // ---------------------------------------------------------------------------
  // Predictor-update FIFO
  // ---------------------------------------------------------------------------
  upd_entry_t       mem_q [UPD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       drop_cnt_q;

  logic push_req_c;
  logic pop_c;
  logic full_c;
  logic do_push_c;
  logic drop_c;

  assign push_req_c = exeValid_i & exeFlags_i[2];
  assign pop_c      = (cnt_q != '0) & updReady_i;
  assign full_c     = cnt_q == CNT_W'(UPD_DEPTH);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push_c  = push_req_c & (~full_c | pop_c);
  assign drop_c     = push_req_c & full_c & ~pop_c;

  // Entry storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < UPD_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_c) begin
      mem_q[wr_ptr_q] <= '{pc: exePC_i, target: exeNextPC_i, dir: exeDirection_i};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push_c && !pop_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (!do_push_c && pop_c) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (drop_c && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Head outputs come straight from flops through the read-pointer mux.
  assign updValid_o   = cnt_q != '0;
  assign updPC_o      = mem_q[rd_ptr_q].pc;
  assign updTarget_o  = mem_q[rd_ptr_q].target;
  assign updDir_o     = mem_q[rd_ptr_q].dir;
  assign updDropCnt_o = drop_cnt_q;

endmodule
